// File: rtl/noise_seq_pkg.sv
// Shared types and default widths for the noise burst sequencer family.
package noise_seq_pkg;

   localparam int unsigned DATA_W_DEF  = 24;
   localparam int unsigned LEN_W_DEF   = 16;
   localparam int unsigned SHIFT_W_DEF = 5;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ADVANCE = 3'd1,
      LOAD    = 3'd2,
      WAIT_N  = 3'd3,
      WAIT_G  = 3'd4,
      DONE    = 3'd5
   } state_e;

endpackage

// File: rtl/noise_atten.sv
// Combinational arithmetic right shift; shifts of DATA_W or more saturate to the sign.
module noise_atten #(
   parameter int unsigned DATA_W  = 24,
   parameter int unsigned SHIFT_W = 5
) (
   input  logic [DATA_W-1:0]  sample_i,
   input  logic [SHIFT_W-1:0] shift_i,
   output logic [DATA_W-1:0]  sample_o
);

   always_comb begin
      sample_o = '0;
      if (32'(shift_i) >= DATA_W) begin
         sample_o = {DATA_W{sample_i[DATA_W-1]}};
      end else begin
         sample_o = $signed(sample_i) >>> shift_i;
      end
   end

endmodule

// File: rtl/noise_burst_sequencer.sv
// Steps an external LFSR noise generator and streams attenuated samples,
// followed by a silent gap, to the codec write port.
module noise_burst_sequencer
   import noise_seq_pkg::*;
#(
   parameter int unsigned DATA_W  = DATA_W_DEF,
   parameter int unsigned LEN_W   = LEN_W_DEF,
   parameter int unsigned SHIFT_W = SHIFT_W_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               abort,
   input  logic [LEN_W-1:0]   burst_len,
   input  logic [LEN_W-1:0]   gap_len,
   input  logic [SHIFT_W-1:0] atten,
   output logic               noise_enable,
   input  logic [DATA_W-1:0]  noise_q,
   input  logic               write_ready,
   output logic               write,
   output logic [DATA_W-1:0]  writedata_left,
   output logic [DATA_W-1:0]  writedata_right,
   output logic               busy,
   output logic               done
);

   state_e              state_q, state_d;
   logic [LEN_W-1:0]    count_q, count_d;
   logic [LEN_W-1:0]    burst_q, burst_d;
   logic [LEN_W-1:0]    gap_q, gap_d;
   logic [SHIFT_W-1:0]  atten_q, atten_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic [DATA_W-1:0]   shifted;
   logic [LEN_W-1:0]    count_inc;

   noise_atten #(
      .DATA_W  (DATA_W),
      .SHIFT_W (SHIFT_W)
   ) u_atten (
      .sample_i (noise_q),
      .shift_i  (atten_q),
      .sample_o (shifted)
   );

   assign count_inc = count_q + LEN_W'(1);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         count_q <= '0;
         burst_q <= '0;
         gap_q   <= '0;
         atten_q <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         burst_q <= burst_d;
         gap_q   <= gap_d;
         atten_q <= atten_d;
         data_q  <= data_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      count_d      = count_q;
      burst_d      = burst_q;
      gap_d        = gap_q;
      atten_d      = atten_q;
      data_d       = data_q;
      noise_enable = 1'b0;
      write        = 1'b0;
      done         = 1'b0;
      busy         = (state_q != IDLE);

      unique case (state_q)
         IDLE: begin
            if (start && !abort) begin
               burst_d = burst_len;
               gap_d   = gap_len;
               atten_d = atten;
               count_d = '0;
               if (burst_len == '0 && gap_len == '0) begin
                  state_d = DONE;
               end else if (burst_len == '0) begin
                  state_d = WAIT_G;
                  data_d  = '0;
               end else begin
                  state_d = ADVANCE;
               end
            end
         end
         ADVANCE: begin
            noise_enable = 1'b1;
            state_d      = LOAD;
         end
         LOAD: begin
            data_d  = shifted;
            state_d = WAIT_N;
         end
         WAIT_N: begin
            write = write_ready && !abort;
            if (write) begin
               if (count_inc == burst_q) begin
                  count_d = '0;
                  if (gap_q != '0) begin
                     state_d = WAIT_G;
                     data_d  = '0;
                  end else begin
                     state_d = DONE;
                  end
               end else begin
                  count_d = count_inc;
                  state_d = ADVANCE;
               end
            end
         end
         WAIT_G: begin
            write = write_ready && !abort;
            if (write) begin
               if (count_inc == gap_q) begin
                  count_d = '0;
                  state_d = DONE;
               end else begin
                  count_d = count_inc;
               end
            end
         end
         DONE: begin
            done    = !abort;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Abort takes priority over every transition out of a busy state.
      if (abort && state_q != IDLE) begin
         state_d = IDLE;
         count_d = '0;
      end
   end

   assign writedata_left  = data_q;
   assign writedata_right = data_q;

endmodule

// File: tb/tb_noise_burst_sequencer.sv
// Scoreboard bench: expected samples are queued at start and popped on each write.
module tb_noise_burst_sequencer;

   logic        clk = 1'b0;
   logic        reset, start, abort, write_ready;
   logic [15:0] burst_len, gap_len;
   logic [4:0]  atten;
   logic        noise_enable, write, busy, done;
   logic [23:0] noise_q, wl, wr;
   logic [23:0] lfsr = 24'hABCDE1;
   logic [23:0] force_val;
   logic        force_en;

   int n_chk = 0, n_bad = 0;
   int n_write = 0, n_ne = 0, n_done = 0;
   logic [23:0] sb[$];

   always #5 clk = ~clk;

   assign noise_q = force_en ? force_val : lfsr;

   noise_burst_sequencer #(
      .DATA_W  (24),
      .LEN_W   (16),
      .SHIFT_W (5)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .start           (start),
      .abort           (abort),
      .burst_len       (burst_len),
      .gap_len         (gap_len),
      .atten           (atten),
      .noise_enable    (noise_enable),
      .noise_q         (noise_q),
      .write_ready     (write_ready),
      .write           (write),
      .writedata_left  (wl),
      .writedata_right (wr),
      .busy            (busy),
      .done            (done)
   );

   function automatic logic [23:0] lfsr_next(input logic [23:0] q);
      return {q[22:0], q[23] ^ q[22] ^ q[21] ^ q[16]};
   endfunction

   function automatic logic [23:0] ref_atten(input logic [23:0] q, input int sh);
      logic [23:0] r;
      for (int i = 0; i < 24; i++) r[i] = (i + sh < 24) ? q[i + sh] : q[23];
      return r;
   endfunction

   always @(posedge clk) if (noise_enable === 1'b1) lfsr <= lfsr_next(lfsr);

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      logic [23:0] e;
      if (noise_enable === 1'b1) n_ne++;
      if (done === 1'b1) n_done++;
      if (write === 1'b1) begin
         n_write++;
         chk("sb_avail", 32'(sb.size() != 0), 1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("sb_left", wl, e);
            chk("sb_right", wr, e);
         end
      end
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   // Returns in cycle 1 of the burst (start was high in cycle 0).
   task automatic start_burst(input int bl, input int gl, input int at);
      logic [23:0] t;
      t = lfsr;
      for (int i = 0; i < bl; i++) begin
         t = lfsr_next(t);
         sb.push_back(ref_atten(force_en ? force_val : t, at));
      end
      for (int i = 0; i < gl; i++) sb.push_back(24'h0);
      step();
      burst_len = 16'(bl);
      gap_len   = 16'(gl);
      atten     = 5'(at);
      start     = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic wait_idle(input int max);
      for (int i = 0; i < max && busy !== 1'b0; i++) begin
         step();
         @(negedge clk);
      end
      chk("idle_timeout", 32'(busy), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got=running exp=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int w0, e0, d0;
      logic [23:0] held;
      logic [23:0] aq [3] = '{24'h800000, 24'h7FFFFF, 24'h800000};
      int          ash[3] = '{4, 30, 30};
      logic [23:0] aex[3] = '{24'hF80000, 24'h000000, 24'hFFFFFF};

      reset = 1'b1; start = 1'b0; abort = 1'b0; write_ready = 1'b1;
      burst_len = '0; gap_len = '0; atten = '0; force_en = 1'b0; force_val = '0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      // Idle after reset
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("idle_ctl", {28'h0, write, noise_enable, busy, done}, 0);
         chk("idle_data", {8'h0, wl | wr}, 0);
      end

      // Basic burst, cycle exact
      d0 = n_done;
      start_burst(3, 0, 0);
      for (int c = 1; c <= 11; c++) begin
         if (c > 1) step();
         @(negedge clk);
         chk("b_ne", 32'(noise_enable), 32'(c == 1 || c == 4 || c == 7));
         chk("b_wr", 32'(write), 32'(c == 3 || c == 6 || c == 9));
         chk("b_done", 32'(done), 32'(c == 10));
         chk("b_busy", 32'(busy), 32'(c <= 10));
      end
      chk("b_done_cnt", n_done - d0, 1);

      // Attenuation corner values
      for (int k = 0; k < 3; k++) begin
         force_en = 1'b1;
         force_val = aq[k];
         start_burst(1, 0, ash[k]);
         wait_idle(20);
         chk("atten_val", wl, aex[k]);
      end
      force_en = 1'b0;

      // Backpressure in WAIT_N
      write_ready = 1'b0;
      w0 = n_write; e0 = n_ne;
      start_burst(2, 0, 3);
      @(negedge clk);
      step(); @(negedge clk);
      step(); @(negedge clk);
      held = wl;
      for (int c = 3; c <= 7; c++) begin
         if (c > 3) step();
         if (c > 3) @(negedge clk);
         chk("bp_write", 32'(write), 0);
         chk("bp_ne", 32'(noise_enable), 0);
         chk("bp_hold", wl, held);
      end
      step();
      write_ready = 1'b1;
      @(negedge clk);
      chk("bp_release", 32'(write), 1);
      wait_idle(30);
      chk("bp_writes", n_write - w0, 2);
      chk("bp_steps", n_ne - e0, 2);

      // Gap after a single sample
      w0 = n_write; e0 = n_ne; d0 = n_done;
      start_burst(1, 3, 2);
      wait_idle(30);
      chk("gap_writes", n_write - w0, 4);
      chk("gap_steps", n_ne - e0, 1);
      chk("gap_done", n_done - d0, 1);
      chk("gap_data", wl, 0);

      // Abort during second WAIT_N
      w0 = n_write; d0 = n_done;
      start_burst(4, 0, 0);
      @(negedge clk);
      for (int c = 2; c <= 5; c++) begin
         step(); @(negedge clk);
      end
      step();
      abort = 1'b1;
      @(negedge clk);
      chk("abort_write", 32'(write), 0);
      chk("abort_busy", 32'(busy), 1);
      step();
      abort = 1'b0;
      @(negedge clk);
      chk("abort_idle", 32'(busy), 0);
      repeat (3) begin step(); @(negedge clk); end
      chk("abort_writes", n_write - w0, 1);
      chk("abort_nodone", n_done - d0, 0);
      sb.delete();

      // Abort and start together in IDLE
      step();
      burst_len = 16'd2; start = 1'b1; abort = 1'b1;
      step();
      start = 1'b0; abort = 1'b0;
      @(negedge clk);
      chk("abort_start", 32'(busy), 0);

      // Start while busy is ignored
      w0 = n_write; d0 = n_done;
      start_burst(2, 0, 1);
      step();
      burst_len = 16'd5; start = 1'b1;
      step();
      start = 1'b0;
      wait_idle(40);
      chk("busy_start_writes", n_write - w0, 2);
      chk("busy_start_done", n_done - d0, 1);
      repeat (3) begin step(); @(negedge clk); end
      chk("busy_start_idle", 32'(busy), 0);

      // Synchronous reset mid-gap
      d0 = n_done;
      start_burst(1, 5, 0);
      for (int c = 2; c <= 4; c++) step();
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      @(negedge clk);
      chk("rst_ctl", {28'h0, write, noise_enable, busy, done}, 0);
      chk("rst_data", {8'h0, wl | wr}, 0);
      sb.delete();
      repeat (10) begin step(); @(negedge clk); end
      chk("rst_nodone", n_done - d0, 0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
